riscv_run_ctrl: RTL and testbench

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

---
 rtl/riscv_run_ctrl.sv | 76 +++++++
 tb/tb_riscv_run_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: loads instruction memory, then runs/steps/halts a CPU core via reset and clock enable
module riscv_run_ctrl #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter logic [31:0] EBREAK     = 32'h00100073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [31:0] cycle_limit,
  input  logic [31:0] instr,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_ld_ptr, r_cycle_cnt;
  logic [1:0]  r_halt_cause;
  logic        w_load, w_run, w_en_c, w_ebreak, w_limit;
  assign w_load   = (r_state == IDLE) || (r_state == LOAD);
  assign w_run    = (r_state == RUN);
  assign w_en_c   = step_mode ? step : 1'b1;
  assign w_ebreak = w_run && w_en_c && (instr == EBREAK);
  assign w_limit  = w_run && w_en_c && (cycle_limit != 32'd0) && (r_cycle_cnt == cycle_limit);
  // next state and outputs; reset gates outputs so they are safe while it is held
  always_comb begin
    w_next     = r_state;
    ld_ready   = !reset && w_load && !start && (r_ld_ptr < IMEM_WORDS);
    imem_we    = ld_valid && ld_ready;
    imem_addr  = r_ld_ptr << 2;
    imem_wdata = ld_data;
    cpu_reset  = reset || w_load;
    cpu_en     = !reset && w_en_c && w_run && !w_ebreak && !w_limit;
    halted     = (r_state == HALT);
    halt_cause = r_halt_cause;
    cycle_cnt  = r_cycle_cnt;
    case (r_state)
      IDLE:    w_next = start ? RUN : (imem_we ? LOAD : IDLE);
      LOAD:    w_next = start ? RUN : LOAD;
      RUN:     w_next = (w_ebreak || w_limit) ? HALT : RUN;
      default: w_next = start ? IDLE : HALT;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // load pointer, cycle counter and halt cause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_ptr     <= '0;
      r_cycle_cnt  <= '0;
      r_halt_cause <= 2'b00;
    end else begin
      if (imem_we) r_ld_ptr <= r_ld_ptr + 32'd1;
      else if (r_state == HALT && start) r_ld_ptr <= '0;
      if (w_load && start) begin
        r_cycle_cnt  <= '0;
        r_halt_cause <= 2'b00;
      end else if (w_ebreak) r_halt_cause <= 2'b01;
      else if (w_limit) r_halt_cause <= 2'b10;
      else if (cpu_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb_riscv_run_ctrl: directed checks of load, run, ebreak, cycle limit, step mode and reset
module tb_riscv_run_ctrl;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;
  logic        clk = 1'b0, reset = 1'b0;
  logic        ld_valid = 1'b0, start = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [31:0] ld_data = '0, cycle_limit = '0, instr = NOP;
  logic        ld_ready, imem_we, cpu_reset, cpu_en, halted;
  logic [31:0] imem_addr, imem_wdata, cycle_cnt;
  logic [1:0]  halt_cause;
  int          n_chk = 0, n_pass = 0, cnt;
  logic [31:0] words [3] = '{32'h00500093, 32'h00100073, 32'h00000000};

  riscv_run_ctrl #(.IMEM_WORDS(4)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .start(start), .step_mode(step_mode), .step(step), .cycle_limit(cycle_limit), .instr(instr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ld_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    ld_valid = 1'b0;
    tick();
    chk("post_rst_ld_ready", 32'(ld_ready), 1);
    // three-word load, run one instruction, halt on ebreak
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data = words[i];
      #1;
      chk("ld_we", 32'(imem_we), 1);
      chk("ld_addr", imem_addr, 32'(i * 4));
      chk("ld_wdata", imem_wdata, words[i]);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    chk("ld_idle_we", 32'(imem_we), 0);
    chk("load_cpu_reset", 32'(cpu_reset), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    instr = 32'h00500093;
    #1;
    chk("run_cpu_reset", 32'(cpu_reset), 0);
    chk("run_cpu_en", 32'(cpu_en), 1);
    tick();
    instr = EBRK;
    #1;
    chk("ebreak_cpu_en", 32'(cpu_en), 0);
    chk("ebreak_cnt_pre", cycle_cnt, 1);
    tick();
    chk("ebreak_halted", 32'(halted), 1);
    chk("ebreak_cause", 32'(halt_cause), 1);
    chk("ebreak_cnt", cycle_cnt, 1);
    chk("halt_cpu_en", 32'(cpu_en), 0);
    chk("halt_cpu_reset", 32'(cpu_reset), 0);
    // HALT + start returns to IDLE with the load pointer cleared
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_cpu_reset", 32'(cpu_reset), 1);
    chk("idle_halted", 32'(halted), 0);
    chk("idle_cause_hold", 32'(halt_cause), 1);
    ld_valid = 1'b1;
    ld_data = 32'hdeadbeef;
    #1;
    chk("reload_addr", imem_addr, 0);
    chk("reload_we", 32'(imem_we), 1);
    tick();
    // start beats a simultaneous ld_valid in LOAD
    start = 1'b1;
    #1;
    chk("start_pri_we", 32'(imem_we), 0);
    chk("start_pri_ready", 32'(ld_ready), 0);
    cycle_limit = 5;
    instr = NOP;
    tick();
    start = 1'b0;
    ld_valid = 1'b0;
    chk("run_entry_cnt", cycle_cnt, 0);
    chk("run_entry_cause", 32'(halt_cause), 0);
    // cycle limit of 5
    cnt = 0;
    for (int i = 0; i < 20 && !halted; i++) begin
      if (cpu_en) cnt++;
      tick();
    end
    chk("limit_en_cycles", 32'(cnt), 5);
    chk("limit_halted", 32'(halted), 1);
    chk("limit_cause", 32'(halt_cause), 2);
    chk("limit_cnt", cycle_cnt, 5);
    // step mode: three pulses four cycles apart
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    cycle_limit = 0;
    step_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step = (i % 4 == 0);
      #1;
      if (cpu_en) cnt++;
      tick();
    end
    step = 1'b0;
    chk("step_en_cycles", 32'(cnt), 3);
    chk("step_cnt", cycle_cnt, 3);
    chk("step_still_run", 32'(halted), 0);
    chk("step_idle_en", 32'(cpu_en), 0);
    step_mode = 1'b0;
    start = 1'b1;
    #1;
    chk("mode_toggle_en", 32'(cpu_en), 1);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0;
    chk("start_in_run_ignored", 32'(cpu_reset), 0);
    chk("pre_reset_cnt", cycle_cnt, 7);
    // reset mid-RUN
    reset = 1'b1;
    #1;
    chk("midrun_rst_en", 32'(cpu_en), 0);
    chk("midrun_rst_cpu_reset", 32'(cpu_reset), 1);
    chk("midrun_rst_cnt", cycle_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrun_rst_idle", 32'(ld_ready), 1);
    // overflow the 4-word memory with 6 offers
    cnt = 0;
    ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_data = 32'(i);
      #1;
      if (imem_we) begin
        chk("fill_addr", imem_addr, 32'(cnt * 4));
        cnt++;
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("fill_writes", 32'(cnt), 4);
    chk("fill_ready", 32'(ld_ready), 0);
    // ebreak wins when the limit is hit in the same cycle
    cycle_limit = 1;
    instr = NOP;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    instr = EBRK;
    #1;
    chk("prio_en", 32'(cpu_en), 0);
    tick();
    chk("prio_cause", 32'(halt_cause), 1);
    chk("prio_cnt", cycle_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
